// File: rtl/risc_pkg.sv
// Shared types for the accumulator CPU: opcode and sequencer phase encodings.
package risc_pkg;

  localparam int NUM_PHASES = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational strobe decode from phase, opcode, zero flag, stall and halted state.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  phase_t     phase,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  input  logic       stall,
  input  logic       halted,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e
);

  logic alu_op;
  assign alu_op = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      // Opcode is only consulted from OP_ADDR on, so an unsettled IR cannot leak out early
      case (phase)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = (opcode == OP_HLT);
          inc_pc = 1'b1;
        end
        OP_FETCH: rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && is_zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: sel = 1'b0;
      endcase
      // Edge strobes must not fire while the phase is held, level signals stay up
      if (stall) begin
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer: phase counter, sticky halt flag and strobe decode.
module risc_controller
  import risc_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  input  logic       stall,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  phase_t phase_q;
  logic   halted;

  // A sticky HLT freezes the phase at OP_ADDR; the PC increment of that phase still lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= INST_ADDR;
      halted  <= 1'b0;
    end else if (!halted && !stall) begin
      if (HALT_STICKY && phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  assign phase = phase_q;

  risc_ctrl_decode u_decode (
    .phase   (phase_q),
    .opcode  (opcode),
    .is_zero (is_zero),
    .stall   (stall),
    .halted  (halted),
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .ld_ac   (ld_ac),
    .ld_pc   (ld_pc),
    .wr      (wr),
    .data_e  (data_e)
  );

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller against a per-phase behavioural model.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       stall;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] phase;
  logic [8:0] act;

  int checks = 0;
  int errors = 0;
  int p = 0;
  bit halted_m = 1'b0;
  logic [2:0] rand_op;

  assign act = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  always #5 clk = ~clk;

  risc_controller dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .is_zero (is_zero),
    .stall   (stall),
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .ld_ac   (ld_ac),
    .ld_pc   (ld_pc),
    .wr      (wr),
    .data_e  (data_e),
    .phase   (phase)
  );

  // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} from the phase rules
  function automatic logic [8:0] model_out(int ph, bit hl, logic [2:0] op, bit z, bit st);
    logic [8:0] e;
    bit alu;
    if (hl) return 9'b000100000;
    alu  = (ph >= 5) && (op >= 3'd2) && (op <= 3'd5);
    e[8] = (ph <= 3);
    e[7] = (ph >= 1 && ph <= 3) || alu;
    e[6] = !st && (ph == 2 || ph == 3);
    e[5] = (ph == 4) && (op == 3'd0);
    e[4] = !st && ((ph == 4) || (ph == 6 && op == 3'd1 && z));
    e[3] = !st && (ph == 7) && alu;
    e[2] = !st && (ph >= 6) && (op == 3'd7);
    e[1] = !st && (ph == 7) && (op == 3'd6);
    e[0] = (ph >= 6) && (op == 3'd6);
    return e;
  endfunction

  task automatic model_step(input logic [2:0] op, input bit st);
    if (!halted_m && !st) begin
      if (p == 4 && op == 3'd0) halted_m = 1'b1;
      else p = (p + 1) % 8;
    end
  endtask

  task automatic advance_to(input int target);
    while (p != target) begin
      @(negedge clk);
      opcode = 3'd2; is_zero = 1'b0; stall = 1'b0;
      #1;
      model_step(opcode, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; opcode = 3'bxxx; is_zero = 1'b0; stall = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (act !== 9'b100000000 || phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b phase %0d, want 100000000 phase 0", act, phase);
    end
    rst = 1'b0;
    p = 0; halted_m = 1'b0;
    advance_to(5);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    p = 0; halted_m = 1'b0;
    checks++;
    if (act !== 9'b100000000 || phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got %b phase %0d, want 100000000 phase 0", act, phase);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = 1'b0; opcode = (p <= 2) ? 3'bxxx : 3'd2; is_zero = 1'b0; stall = 1'b0;
      #1;
      checks++;
      if (act !== model_out(p, halted_m, opcode, is_zero, stall) || phase !== 3'(p)) begin
        errors++;
        $display("FAIL reset_seq cyc %0d: got %b phase %0d, want %b phase %0d",
                 i, act, phase, model_out(p, halted_m, opcode, is_zero, stall), p);
      end
      model_step(opcode, stall);
    end
  endtask

  task automatic test_instr(input logic [2:0] op, input bit z);
    advance_to(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      opcode = op; is_zero = z; stall = 1'b0;
      #1;
      checks++;
      if (act !== model_out(p, halted_m, opcode, is_zero, stall) || phase !== 3'(p)) begin
        errors++;
        $display("FAIL instr op%0d z%0d ph%0d: got %b phase %0d, want %b phase %0d",
                 op, z, p, act, phase, model_out(p, halted_m, opcode, is_zero, stall), p);
      end
      model_step(opcode, stall);
    end
  endtask

  task automatic test_stall;
    advance_to(7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      opcode = 3'd2; is_zero = 1'b0; stall = (i < 3);
      #1;
      checks++;
      if (act !== model_out(p, halted_m, opcode, is_zero, stall) || phase !== 3'(p)) begin
        errors++;
        $display("FAIL stall cyc %0d: got %b phase %0d, want %b phase %0d",
                 i, act, phase, model_out(p, halted_m, opcode, is_zero, stall), p);
      end
      model_step(opcode, stall);
    end
  endtask

  task automatic test_random;
    rand_op = 3'd1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (p <= 2) begin
        opcode  = 3'bxxx;
        rand_op = 3'($urandom_range(7, 1));
      end else begin
        opcode = rand_op;
      end
      is_zero = 1'($urandom);
      stall   = ($urandom_range(3, 0) == 0);
      #1;
      checks++;
      if (act !== model_out(p, halted_m, opcode, is_zero, stall) || phase !== 3'(p)) begin
        errors++;
        $display("FAIL random cyc %0d op %b: got %b phase %0d, want %b phase %0d",
                 i, opcode, act, phase, model_out(p, halted_m, opcode, is_zero, stall), p);
      end
      model_step(opcode, stall);
    end
  endtask

  task automatic test_halt;
    advance_to(0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      opcode = 3'd0; is_zero = 1'($urandom);
      stall  = halted_m ? 1'($urandom) : 1'b0;
      #1;
      checks++;
      if (act !== model_out(p, halted_m, opcode, is_zero, stall) || phase !== 3'(p)) begin
        errors++;
        $display("FAIL halt cyc %0d: got %b phase %0d, want %b phase %0d",
                 i, act, phase, model_out(p, halted_m, opcode, is_zero, stall), p);
      end
      model_step(opcode, stall);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    p = 0; halted_m = 1'b0;
    checks++;
    if (act !== 9'b100000000 || phase !== 3'd0) begin
      errors++;
      $display("FAIL halt_reset: got %b phase %0d, want 100000000 phase 0", act, phase);
    end
    @(negedge clk);
    rst = 1'b0; opcode = 3'bxxx; stall = 1'b0;
    #1;
    checks++;
    if (act !== 9'b100000000 || phase !== 3'd0) begin
      errors++;
      $display("FAIL halt_release: got %b phase %0d, want 100000000 phase 0", act, phase);
    end
  endtask

  initial begin
    test_reset();
    test_instr(3'd2, 1'b0);
    test_instr(3'd1, 1'b1);
    test_instr(3'd1, 1'b0);
    test_instr(3'd6, 1'b0);
    test_instr(3'd7, 1'b1);
    test_instr(3'd5, 1'b1);
    test_stall();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
